uart_tx_arbiter: RTL and testbench

Shares one uart_tx transmitter between NUM_REQ byte sources, e.g. the rx echo path and a status/message generator. Round-robin arbitration at packet granularity: a requester keeps the transmitter from its first byte until a byte flagged last, so multi-byte messages are never interleaved. Drives uart_tx en/data_in and sequences on its rdy; a lock timeout frees the transmitter if a packet owner stalls.

---
 rtl/uart_tx_arbiter_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
// Holds the arbiter state encoding and small elaboration-time helpers.
package uart_tx_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int SYSTEM_CLOCK   = 32_000_000;
    localparam int BAUD_RATE      = 115_200;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_e;

    // Index following idx in a ring of n requesters; a single requester stays at 0.
    function automatic int rr_next(input int idx, input int n);
        return (n > 1) ? ((idx + 1) % n) : 0;
    endfunction

    // Counter/index width for a limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid index at or after ptr,
// wrapping, reported both one-hot and as an index.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      idx,
    output logic               any
);

    int best_dist_s;
    int best_idx_s;
    int dist_s;

    // Nearest valid requester measured as ring distance from the pointer.
    always_comb begin
        best_dist_s = NUM_REQ;
        best_idx_s  = 0;
        dist_s      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                best_idx_s  = i;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    assign any    = |valid;
    assign winner = any ? (NUM_REQ'(1'b1) << best_idx_s) : '0;
    assign idx    = PW'(best_idx_s);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ byte sources,
// with a guard for missed rdy drops and a lock timeout for stalled owners.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RDY_GUARD    = 4,
    parameter int LOCK_TIMEOUT = 32000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_rdy,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          lock_timeout
);

    localparam int PW = cnt_width(NUM_REQ);
    localparam int GW = cnt_width(RDY_GUARD);
    localparam int TW = cnt_width(LOCK_TIMEOUT);
    localparam logic [GW-1:0] GUARD_LAST = GW'(RDY_GUARD - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(LOCK_TIMEOUT - 1);

    arb_state_e            state_r, next_state_s;
    logic [PW-1:0]         ptr_r, owner_r, pick_idx_s;
    logic [NUM_REQ-1:0]    pick_oh_s, grant_r, ready_s, take_oh_s;
    logic                  pick_any_s, take_s, release_s, timeout_s;
    logic                  last_r, take_last_s;
    logic [DATA_WIDTH-1:0] tx_data_r, take_data_s;
    logic                  tx_en_r, busy_r, lock_timeout_r;
    logic [GW-1:0]         guard_cnt_r;
    logic [TW-1:0]         hold_cnt_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr_r),
        .winner (pick_oh_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Next-state, handshake and release decisions.
    always_comb begin
        next_state_s = state_r;
        ready_s      = '0;
        release_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (tx_rdy && pick_any_s) begin
                    ready_s      = pick_oh_s;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_ARB;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never drops rdy is assumed to have taken the byte.
                if (!tx_rdy || (guard_cnt_r == GUARD_LAST)) begin
                    next_state_s = ST_WAIT_DONE;
                end else begin
                    next_state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_rdy) begin
                    next_state_s = ST_WAIT_DONE;
                end else if (last_r) begin
                    release_s    = 1'b1;
                    next_state_s = ST_ARB;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                ready_s = grant_r & {NUM_REQ{tx_rdy}};
                if (|(ready_s & req_valid)) begin
                    next_state_s = ST_ISSUE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    timeout_s    = 1'b1;
                    release_s    = 1'b1;
                    next_state_s = ST_ARB;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_ARB;
            end
        endcase
    end

    assign take_oh_s = ready_s & req_valid;
    assign take_s    = |take_oh_s;

    // Byte and last flag of whichever requester is handing over this cycle.
    always_comb begin
        take_data_s = '0;
        take_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take_oh_s[i]) begin
                take_data_s = take_data_s | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                take_last_s = take_last_s | req_last[i];
            end else begin
                take_data_s = take_data_s;
            end
        end
    end

    // State, ownership and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_ARB;
            ptr_r          <= '0;
            owner_r        <= '0;
            grant_r        <= '0;
            last_r         <= 1'b0;
            tx_data_r      <= '0;
            tx_en_r        <= 1'b0;
            busy_r         <= 1'b0;
            lock_timeout_r <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            tx_en_r        <= (next_state_s == ST_ISSUE);
            busy_r         <= (next_state_s != ST_ARB);
            lock_timeout_r <= timeout_s;
            if (take_s) begin
                tx_data_r <= take_data_s;
                last_r    <= take_last_s;
            end
            if ((state_r == ST_ARB) && take_s) begin
                owner_r <= pick_idx_s;
                grant_r <= pick_oh_s;
            end else if (release_s) begin
                grant_r <= '0;
                ptr_r   <= PW'(rr_next(int'(owner_r), NUM_REQ));
            end
        end
    end

    // Guard and hold counters: saturating, cleared whenever their state is left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            guard_cnt_r <= '0;
            hold_cnt_r  <= '0;
        end else begin
            if (state_r != ST_WAIT_BUSY) begin
                guard_cnt_r <= '0;
            end else if (guard_cnt_r != GUARD_LAST) begin
                guard_cnt_r <= guard_cnt_r + GW'(1);
            end
            if ((state_r != ST_HOLD) || take_s || release_s) begin
                hold_cnt_r <= '0;
            end else if (hold_cnt_r != HOLD_LAST) begin
                hold_cnt_r <= hold_cnt_r + TW'(1);
            end
        end
    end

    assign req_ready    = ready_s;
    assign tx_en        = tx_en_r;
    assign tx_data      = tx_data_r;
    assign grant        = grant_r;
    assign busy         = busy_r;
    assign lock_timeout = lock_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet rounds,
// checked against a packet-level round-robin model and a mock uart_tx.
module tb_uart_tx_arbiter;

    localparam int NR    = 3;
    localparam int DW    = 8;
    localparam int GUARD = 4;
    localparam int LT    = 40;
    localparam int QD    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic          tx_rdy;
    logic [NR-1:0] grant;
    logic          busy;
    logic          lock_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .RDY_GUARD    (GUARD),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_rdy       (tx_rdy),
        .grant        (grant),
        .busy         (busy),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // Requester byte queues: {last, data}
    logic [8:0]  mem [NR][QD];
    int          head [NR];
    int          tail [NR];
    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mptr;
    bit          guard_mode;
    int          busy_len;
    int          busy_left;

    logic [NR-1:0] s_ready, s_grant;
    logic          s_tx_en, s_busy, s_lt;
    logic [DW-1:0] s_tx_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = mem[i][head[i]][7:0];
                req_last[i]           = mem[i][head[i]][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic reset_queues();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        present();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) e = 1'b0;
        return e;
    endfunction

    // One clock: sample mid-cycle, then update requesters and the mock uart_tx.
    task automatic cycle();
        logic [NR-1:0] hs;
        @(negedge clk);
        s_ready   = req_ready;
        s_grant   = grant;
        s_tx_en   = tx_en;
        s_tx_data = tx_data;
        s_busy    = busy;
        s_lt      = lock_timeout;
        hs        = req_valid & req_ready;
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'h1);
        check("ready_needs_rdy", 32'(req_ready & ~{NR{tx_rdy}}), 32'h0);
        check("ready_is_owner",
              32'((grant == '0) || (req_ready == '0) || (req_ready == grant)), 32'h1);
        if (tx_en) obs_q.push_back({5'b0, grant, tx_data});
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (hs[i]) head[i]++;
        if (s_tx_en && !guard_mode) begin
            tx_rdy    = 1'b0;
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_rdy = 1'b1;
        end
        present();
    endtask

    // Packet-level model: whole packets in ring order from the pointer.
    task automatic model_expect();
        int         h [NR];
        int         idx;
        bit         found, done;
        logic [8:0] b;
        for (int i = 0; i < NR; i++) h[i] = head[i];
        forever begin
            found = 1'b0;
            idx   = 0;
            for (int k = 0; k < NR; k++) begin
                if (!found && (h[(mptr + k) % NR] < tail[(mptr + k) % NR])) begin
                    found = 1'b1;
                    idx   = (mptr + k) % NR;
                end
            end
            if (!found) break;
            done = 1'b0;
            while (!done && (h[idx] < tail[idx])) begin
                b = mem[idx][h[idx]];
                h[idx]++;
                exp_q.push_back({5'b0, NR'(1 << idx), b[7:0]});
                done = b[8];
            end
            mptr = (idx + 1) % NR;
        end
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++)
            check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(all_empty() && !busy && (grant == '0)) && (n < budget));
        check("drain_budget", 32'(n < budget), 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"}, 32'(tx_en), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_lock_to"}, 32'(lock_timeout), 32'h0);
    endtask

    initial begin
        int  n_busy;
        int  n_hold;
        bit  seen;
        int  np, len;

        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tx_rdy     = 1'b1;
        guard_mode = 1'b0;
        busy_len   = 3;
        busy_left  = 0;
        mptr       = 0;
        reset_queues();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) cycle();

        // Single-byte packet
        push(0, 8'h41, 1'b1);
        model_expect();
        present();
        cycle();
        check("t1_ready_same_cycle", 32'(s_ready), 32'h1);
        check("t1_no_en_at_accept", 32'(s_tx_en), 32'h0);
        cycle();
        check("t1_en_next_cycle", 32'(s_tx_en), 32'h1);
        check("t1_tx_data", 32'(s_tx_data), 32'h41);
        check("t1_grant", 32'(s_grant), 32'h1);
        run_until_idle(200);
        check("t1_grant_released", 32'(grant), 32'h0);
        compare_streams("t1");

        // Contention: strict alternation over four single-byte packets
        reset_queues();
        push(0, 8'hC0, 1'b1);
        push(0, 8'hC1, 1'b1);
        push(1, 8'hD0, 1'b1);
        push(1, 8'hD1, 1'b1);
        model_expect();
        present();
        run_until_idle(400);
        compare_streams("t2");

        // Lock: multi-byte packet is never interleaved
        reset_queues();
        push(1, 8'h48, 1'b0);
        push(1, 8'h49, 1'b0);
        push(1, 8'h0A, 1'b1);
        push(0, 8'h30, 1'b1);
        model_expect();
        present();
        run_until_idle(400);
        compare_streams("t3");

        // Guard: tx_rdy never drops after tx_en
        reset_queues();
        guard_mode = 1'b1;
        push(2, 8'h77, 1'b1);
        model_expect();
        present();
        cycle();
        check("t4_ready", 32'(s_ready), 32'h4);
        cycle();
        check("t4_en", 32'(s_tx_en), 32'h1);
        n_busy = 0;
        for (int k = 0; (k < 20) && busy; k++) begin
            cycle();
            if (s_busy) n_busy++;
        end
        check("t4_guard_cycles", 32'(n_busy), 32'(GUARD + 1));
        repeat (5) cycle();
        compare_streams("t4");
        guard_mode = 1'b0;

        // Timeout: owner stalls mid-packet
        reset_queues();
        push(0, 8'h55, 1'b0);
        push(1, 8'h62, 1'b1);
        model_expect();
        present();
        n_hold = 0;
        seen   = 1'b0;
        for (int k = 0; (k < 200) && !seen; k++) begin
            cycle();
            if ((s_grant == 3'b001) && (s_ready == 3'b001)) n_hold++;
            seen = s_lt;
        end
        check("t5_timeout_seen", 32'(seen), 32'h1);
        check("t5_hold_cycles", 32'(n_hold), 32'(LT));
        check("t5_grant_at_pulse", 32'(s_grant), 32'h0);
        check("t5_next_winner", 32'(s_ready), 32'h2);
        cycle();
        check("t5_pulse_width", 32'(s_lt), 32'h0);
        run_until_idle(400);
        compare_streams("t5");

        // Reset mid-byte
        reset_queues();
        push(0, 8'h99, 1'b1);
        present();
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        obs_q.delete();
        exp_q.delete();
        reset_queues();
        tx_rdy    = 1'b1;
        busy_left = 0;
        mptr      = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) cycle();
        check("t6_no_en_after_release", 32'(obs_q.size()), 32'h0);
        push(0, 8'hA0, 1'b1);
        push(1, 8'hB1, 1'b1);
        model_expect();
        present();
        cycle();
        check("t6_pointer_zero", 32'(s_ready), 32'h1);
        run_until_idle(400);
        compare_streams("t6");

        // Randomized packet rounds
        for (int r = 0; r < 12; r++) begin
            reset_queues();
            guard_mode = ($urandom_range(0, 3) == 0);
            busy_len   = $urandom_range(1, 6);
            for (int i = 0; i < NR; i++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == (len - 1));
                end
            end
            model_expect();
            present();
            run_until_idle(2000);
            compare_streams("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
